fifo_burst_reader: RTL and testbench

Read-side engine for the team's synchronous FIFO. On a start command it pops a programmed number of words from the FIFO's read port (rd_en/data_out/empty) and re-presents them as a valid/ready stream with a last flag. It absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so full throughput is kept under downstream backpressure. It sits between the FIFO and any stream consumer.

---
 rtl/fifo_rd_pkg.sv | 12 +
 rtl/stream_skid_buf.sv | 67 ++++++
 rtl/fifo_burst_reader.sv | 113 +++++++++++
 tb/tb_fifo_burst_reader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and constants for the FIFO burst reader
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rd_state_t;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - small circular output buffer with push/pop, count and head word
import fifo_rd_pkg::*;

module stream_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [$clog2(BUF_DEPTH+1)-1:0] count,
    output logic [DATA_W-1:0]             head_data
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [DATA_W-1:0] mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        do_pop  = pop && (count_q != '0);
        // A full buffer can still take a word in the cycle its head leaves.
        do_push = push && ((count_q != CNT_W'(BUF_DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[tail_q] = push_data;
            tail_d        = ptr_inc(tail_q);
        end
        if (do_pop) begin
            head_d = ptr_inc(head_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops a programmed burst from a FIFO and replays it as a stream
import fifo_rd_pkg::*;

module fifo_burst_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    rd_state_t        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] sent_q, sent_d;
    logic             inflight_q, inflight_d;

    logic [CNT_W-1:0] occ;
    logic [CNT_W:0]   pending;
    logic             pop;
    logic             last_word;
    logic             rd_en;

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .count     (occ),
        .head_data (m_data)
    );

    assign m_valid   = (occ != '0);
    assign pop       = m_valid && m_ready;
    assign last_word = (sent_q == len_q - LEN_W'(1));
    assign m_last    = m_valid && last_word;
    // Words the buffer must hold next cycle: current, plus the read in flight, minus this pop.
    assign pending   = {1'b0, occ} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        rd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = burst_len;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                rd_en = !fifo_empty && (issued_q < len_q) && (pending < (CNT_W+1)'(BUF_DEPTH));
                if (rd_en) begin
                    issued_d = issued_q + LEN_W'(1);
                end
                if (pop) begin
                    sent_d = sent_q + LEN_W'(1);
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        inflight_d = rd_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= inflight_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - scoreboard bench for fifo_burst_reader with a FIFO model
import fifo_rd_pkg::*;

module tb_fifo_burst_reader;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic              busy, done, fifo_rd_en, m_valid, m_last;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO with one-cycle read latency and a registered empty flag
    int rd_total = 0;
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_data <= fifo_q.pop_front();
            rd_total++;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: samples 1 time unit after each falling edge
    int   cyc = 0, done_cnt = 0, hs_cnt = 0, busy_cnt = 0, rd_cnt = 0, val_cnt = 0;
    int   start_cyc = -1, first_rd = -1, first_val = -1, first_hs = -1, last_hs = -1;
    int   occ_m = 0, infl_m = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic hs;
    exp_t e;

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst) begin
            occ_m      = 0;
            infl_m     = 0;
            prev_stall = 1'b0;
        end else begin
            hs = m_valid && m_ready;
            if (start && !busy) begin
                start_cyc = cyc;
                first_rd  = -1;
                first_val = -1;
                first_hs  = -1;
            end
            if (fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                chk("rd_while_empty", 32'(fifo_empty), 0);
                chk("occ_bound", 32'((occ_m + infl_m - int'(hs)) < 2), 1);
            end
            chk("valid_vs_model", 32'(m_valid), 32'(occ_m > 0));
            if (m_valid) begin
                val_cnt++;
                if (first_val < 0) first_val = cyc;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 32'(busy), 1);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
                chk("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (hs) begin
                hs_cnt++;
                last_hs = cyc;
                if (first_hs < 0) first_hs = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(m_data), 32'(e.data));
                    chk("last", 32'(m_last), 32'(e.last));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            occ_m      = occ_m + infl_m - int'(hs);
            infl_m     = int'(fifo_rd_en);
        end
    end

    int ready_mode = 0;
    int rk = 0;

    task automatic tick();
        @(negedge clk);
        if (ready_mode == 0) begin
            m_ready = 1'b1;
        end else begin
            m_ready = ((rk % 4) == 0) || ((rk % 4) == 3);
            rk++;
        end
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        tick();
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            #2;
            if (done_cnt > d0) break;
            tick();
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > d0), 1);
        tick();
        #2;
        chk({tag, "_busy_low"}, 32'(busy), 0);
    endtask

    task automatic load(input logic [7:0] d, input logic last, input bit expect_it);
        tick();
        fifo_q.push_back(d);
        if (expect_it) exp_q.push_back('{data: d, last: last});
    endtask

    logic [7:0] t1w [5];
    int r0, h0, d0, v0, b0;

    initial begin
        t1w = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D};

        // reset state
        tick(); tick();
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_last", 32'(m_last), 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: five words, m_ready always high
        ready_mode = 0;
        for (int i = 0; i < 5; i++) load(t1w[i], i == 4, 1'b1);
        tick();
        r0 = rd_total; d0 = done_cnt; h0 = hs_cnt;
        do_start(8'd5);
        wait_done("t1", 50);
        chk("t1_rd_latency", 32'(first_rd - start_cyc), 1);
        chk("t1_valid_latency", 32'(first_val - start_cyc), 3);
        chk("t1_back_to_back", 32'(last_hs - first_hs), 4);
        chk("t1_words", 32'(hs_cnt - h0), 5);
        chk("t1_fifo_reads", 32'(rd_total - r0), 5);
        chk("t1_fifo_empty", 32'(fifo_q.size()), 0);
        chk("t1_done_pulses", 32'(done_cnt - d0), 1);
        chk("t1_sb_empty", 32'(exp_q.size()), 0);

        // 2: same data with backpressure 1,0,0,1,...
        for (int i = 0; i < 5; i++) load(t1w[i], i == 4, 1'b1);
        tick();
        ready_mode = 1; rk = 0;
        r0 = rd_total; d0 = done_cnt; h0 = hs_cnt;
        do_start(8'd5);
        wait_done("t2", 100);
        chk("t2_words", 32'(hs_cnt - h0), 5);
        chk("t2_fifo_reads", 32'(rd_total - r0), 5);
        chk("t2_done_pulses", 32'(done_cnt - d0), 1);
        chk("t2_sb_empty", 32'(exp_q.size()), 0);

        // 3: FIFO runs dry mid-burst, refilled later
        ready_mode = 0;
        load(8'hA1, 1'b0, 1'b1);
        load(8'hB2, 1'b0, 1'b1);
        exp_q.push_back('{data: 8'hC3, last: 1'b0});
        exp_q.push_back('{data: 8'hD4, last: 1'b1});
        tick();
        h0 = hs_cnt; r0 = rd_total;
        do_start(8'd4);
        repeat (8) tick();
        #2;
        chk("t3_stall_valid", 32'(m_valid), 0);
        chk("t3_stall_rd_en", 32'(fifo_rd_en), 0);
        chk("t3_stall_busy", 32'(busy), 1);
        chk("t3_stall_words", 32'(hs_cnt - h0), 2);
        load(8'hC3, 1'b0, 1'b0);
        load(8'hD4, 1'b1, 1'b0);
        wait_done("t3", 50);
        chk("t3_words", 32'(hs_cnt - h0), 4);
        chk("t3_fifo_reads", 32'(rd_total - r0), 4);
        chk("t3_sb_empty", 32'(exp_q.size()), 0);

        // 4: zero-length burst
        r0 = rd_cnt; v0 = val_cnt; b0 = busy_cnt; d0 = done_cnt;
        do_start(8'd0);
        wait_done("t4", 10);
        chk("t4_no_reads", 32'(rd_cnt - r0), 0);
        chk("t4_no_valid", 32'(val_cnt - v0), 0);
        chk("t4_busy_short", 32'((busy_cnt - b0) >= 1 && (busy_cnt - b0) <= 2), 1);
        chk("t4_done_pulses", 32'(done_cnt - d0), 1);

        // 5: restart attempt while busy is ignored
        load(8'h11, 1'b0, 1'b1);
        load(8'h22, 1'b0, 1'b1);
        load(8'h33, 1'b1, 1'b1);
        load(8'h44, 1'b0, 1'b0);
        load(8'h55, 1'b0, 1'b0);
        tick();
        h0 = hs_cnt; r0 = rd_total;
        do_start(8'd3);
        tick();
        start = 1'b1; burst_len = 8'd7;
        tick();
        start = 1'b0;
        wait_done("t5", 50);
        repeat (3) tick();
        #2;
        chk("t5_still_idle", 32'(busy), 0);
        chk("t5_words", 32'(hs_cnt - h0), 3);
        chk("t5_fifo_reads", 32'(rd_total - r0), 3);
        chk("t5_fifo_left", 32'(fifo_q.size()), 2);
        chk("t5_sb_empty", 32'(exp_q.size()), 0);

        // 6: reset after second handshake, then a clean len=1 burst
        exp_q.push_back('{data: 8'h44, last: 1'b0});
        exp_q.push_back('{data: 8'h55, last: 1'b0});
        load(8'h66, 1'b0, 1'b1);
        load(8'h77, 1'b0, 1'b1);
        load(8'h88, 1'b1, 1'b1);
        tick();
        h0 = hs_cnt;
        do_start(8'd5);
        for (int i = 0; i < 40; i++) begin
            #2;
            if (hs_cnt - h0 >= 2) break;
            tick();
        end
        chk("t6_two_words", 32'(hs_cnt - h0), 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_done", 32'(done), 0);
        chk("t6_rst_rd_en", 32'(fifo_rd_en), 0);
        chk("t6_rst_valid", 32'(m_valid), 0);
        chk("t6_rst_data", 32'(m_data), 0);
        chk("t6_rst_last", 32'(m_last), 0);
        chk("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
        exp_q.delete();
        fifo_q.delete();
        tick(); tick();
        rst = 1'b0;
        load(8'h5A, 1'b1, 1'b1);
        tick();
        h0 = hs_cnt;
        do_start(8'd1);
        wait_done("t6b", 20);
        chk("t6b_words", 32'(hs_cnt - h0), 1);
        chk("t6b_sb_empty", 32'(exp_q.size()), 0);

        // 7: maximum length burst must not wrap
        for (int i = 0; i < 255; i++) load(8'(i * 7 + 3), i == 254, 1'b1);
        tick();
        h0 = hs_cnt; r0 = rd_total;
        do_start(8'd255);
        wait_done("t7", 600);
        chk("t7_words", 32'(hs_cnt - h0), 255);
        chk("t7_fifo_reads", 32'(rd_total - r0), 255);
        chk("t7_throughput", 32'(last_hs - first_hs), 254);
        chk("t7_sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule
